// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared constants and types for the two-port RAM arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default RAM address / data widths
//   port_e                  : requester index (PORT0, PORT1)
//   LAST_RST                : reset value of the "last granted" pointer, chosen
//                             so that port 0 wins the first contention
package ram_arb_pkg;
  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  localparam port_e LAST_RST = PORT1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way picker.
//   req[1:0] : pending requests, bit N = port N
//   last     : port granted most recently (present only with RAM_ARB_RR_EN)
//   gnt[1:0] : one-hot grant (all zero when nothing is pending)
// Build option RAM_ARB_RR_EN: defined -> round-robin on contention,
// undefined -> fixed priority with port 0 always winning contention.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
`ifdef RAM_ARB_RR_EN
  input  port_e      last,
`endif
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
`ifdef RAM_ARB_RR_EN
      // Contention: the port that did not win last time goes now.
      gnt = (last == PORT0) ? 2'b10 : 2'b01;
`else
      gnt = 2'b01;
`endif
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM (1-cycle read latency)
// between two requesters.
//   clk, rst                 : clock, asynchronous active-high reset
//   reqN/weN/addrN/wdataN    : request from port N, held until gntN
//   gntN                     : request accepted this cycle (combinational)
//   rvalidN/rdataN           : read data return, rvalidN is a 1-cycle pulse
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata : RAM command and read data
// Build option RAM_ARB_RR_EN: defined -> round-robin arbitration with a
// registered "last granted" pointer; undefined -> fixed priority, port 0 wins.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic [1:0] pick;
  logic [1:0] gnt;
  logic       rd_pend;
  port_e      rd_port;

`ifdef RAM_ARB_RR_EN
  port_e last;

  rr_arb2 u_arb (
    .req  ({req1, req0}),
    .last (last),
    .gnt  (pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last <= LAST_RST;
    else if (|gnt)   last <= gnt[1] ? PORT1 : PORT0;
  end
`else
  rr_arb2 u_arb (
    .req  ({req1, req0}),
    .gnt  (pick)
  );
`endif

  // Nothing is granted while reset is held, so no access reaches the RAM.
  assign gnt  = rst ? 2'b00 : pick;
  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

  // Command mux; ram_we is qualified so an idle cycle never writes.
  assign ram_en    = |gnt;
  assign ram_we    = gnt[1] ? we1 : (gnt[0] & we0);
  assign ram_addr  = gnt[1] ? addr1  : addr0;
  assign ram_wdata = gnt[1] ? wdata1 : wdata0;

  // Remember which port owns the read in flight; the RAM answers next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_port <= PORT0;
    end else begin
      rd_pend <= ram_en & ~ram_we;
      if (ram_en) rd_port <= gnt[1] ? PORT1 : PORT0;
    end
  end

  assign rvalid0 = rd_pend & (rd_port == PORT0);
  assign rvalid1 = rd_pend & (rd_port == PORT1);

  // Data path is shared; rvalidN says whose it is.
  assign rdata0 = ram_rdata;
  assign rdata1 = ram_rdata;

endmodule
